line_option_feeder: RTL and testbench
=====================================

# line_option_feeder

Sequencer on the driving side of the solver's option stream. It holds the candidate options for every row and column, keeps a circular queue of line indices still to be processed, and issues each line as one index word followed by its option words. It samples the solver's `put_back_to_FIFO` verdict after each line and re-queues unresolved lines, stopping when the solver reports `solved`, the queue drains, or an issue budget runs out.

## Interface
- `SIZE`, default 3: board dimension. There are 2*SIZE lines: rows 0..SIZE-1, then columns SIZE..2*SIZE-1. SIZE ≥ 3, so LW ≤ SIZE.
- `MAX_OPTS`, default 8: option slots per line.
- `MAX_ISSUES`, default 1023: line-issue budget before timeout.
- Derived: LW = $clog2(2*SIZE); CW = $clog2(MAX_OPTS+1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  appends `load_opt` to line `load_line`; honoured only in IDLE.
- `load_line`  in  LW  target line; values ≥ 2*SIZE are ignored and set `err`.
- `load_opt`  in  SIZE  option bit pattern; bit SIZE-1 is cell 0.
- `start`  in  1  one-cycle pulse that begins streaming; honoured only in IDLE.
- `put_back_to_FIFO`  in  1  solver verdict; sampled only in RESULT.
- `solved`  in  1  solver reports the board is complete.
- `option`  out  SIZE  index word (zero-extended line index) or option word.
- `valid_op`  out  1  `option` is valid this cycle.
- `started`  out  1  high from INDEX entry until DONE.
- `done`  out  1  high in DONE; cleared only by `rst`.
- `timeout`  out  1  sticky; set when the issue budget is exhausted.
- `err`  out  1  sticky; set by bad load index, option overflow, or a zero-option line.
- `lines_issued`  out  16  count of index words emitted; saturates.

## Operation
- Storage: option memory [2*SIZE][MAX_OPTS] of SIZE bits, a per-line count of CW bits, and a queue of 2*SIZE LW-bit entries with head, tail and occupancy.
- Loading in IDLE: each `load_valid` writes slot count[line] and then increments the count. If the count already equals MAX_OPTS, the word is dropped and `err` is set.
- `start` in IDLE: the queue is filled with 0..2*SIZE-1 in one cycle (head=0, tail=0, occupancy=2*SIZE), and the block moves to POP.
- POP: if occupancy is 0, go to DONE. Otherwise dequeue line L. If count[L]==0, set `err`, drop L and stay in POP. Otherwise go to INDEX.
- INDEX (1 cycle): `valid_op`=1, `option`=L, `lines_issued`+1, k←0, then go to OPTS.
- OPTS (count[L] cycles): `valid_op`=1, `option`=mem[L][k], k+1. After the last word, go to RESULT.
- RESULT (1 cycle): `valid_op`=0. If `put_back_to_FIFO`=1, enqueue L at the tail. Next state:
  - DONE if `lines_issued` ≥ MAX_ISSUES; `timeout` is set.
  - POP otherwise.
- `solved`=1 in any state except IDLE moves the block to DONE on the next edge. A line in progress is abandoned and `valid_op` drops that edge.
- DONE: `done`=1, `started`=0, `valid_op`=0. Loads and `start` are ignored.
- The queue cannot overflow: each line is in the queue at most once, because it is dequeued before it can be re-enqueued. The head and tail pointers wrap modulo 2*SIZE.

## Timing
- Reset values:
  - All outputs 0; `option`=0.
  - Queue empty, all counts 0, state IDLE.
  - Reset asserted mid-stream aborts immediately (asynchronous) and clears loaded options.
- `start` in cycle t: POP at t+1; the first index word is valid at t+2.
- A line with n options occupies n+1 consecutive `valid_op` cycles, then one RESULT gap cycle, then one POP cycle. Per-line period is n+3 cycles.
- `put_back_to_FIFO` must be valid in the cycle after the last option word. A re-queued line is visible to POP on the following cycle.
- If `solved` and `put_back_to_FIFO` are both high in RESULT, `solved` wins and the line is not re-queued.
- `start` coincident with `load_valid`: the load is applied first, and the queue fill sees the updated counts.

## Test plan
- Reset, then load the 3×3 board: row0 {110,011}, row1 {100,010,001}, row2 {101}, col0 {101}, col1 {110,011}, col2 {100,010,001}. Pulse `start` with `put_back_to_FIFO`=0 and `solved`=0 → stream is 000,110,011, 001,100,010,001, 010,101, 011,101, 100,110,011, 101,100,010,001. Each line is separated by 2 invalid cycles; then `done`=1 and `lines_issued`=6.
- Same board with `put_back_to_FIFO`=1 only for lines 0 and 1 on the first pass → after line 5, lines 0 then 1 are reissued; `lines_issued`=8.
- Assert `solved` during row1's second option word → `valid_op`=0 and `done`=1 on the next edge; no further index words.
- Load 9 options into line 2 with MAX_OPTS=8 → `err`=1 and count[2]=8. Leave line 4 empty → line 4 is skipped; stream order is 0,1,2,3,5.
- Set MAX_ISSUES=3 and hold `put_back_to_FIFO`=1 → exactly 3 index words are issued, then `timeout`=1 and `done`=1.
- Assert `rst` mid-OPTS → all outputs 0 immediately; a new load and `start` replay the first scenario exactly.

Source files
------------

// File: rtl/line_option_feeder.sv
// line_option_feeder: sequencer on the driving side of the solver's option stream.
// Holds candidate options per row/column, keeps a circular queue of lines still
// to be processed, and issues each line as one index word followed by its
// option words. Lines the solver hands back are re-queued until the solver
// reports solved, the queue drains, or the issue budget is exhausted.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_valid        append load_opt to line load_line (IDLE only)
//   load_line         target line (rows 0..SIZE-1, columns SIZE..2*SIZE-1)
//   load_opt          option bit pattern, bit SIZE-1 is cell 0
//   start             begin streaming (IDLE only)
//   put_back_to_FIFO  solver verdict, sampled in the cycle after the last option
//   solved            solver reports the board complete
//   option            index word (zero-extended line) or option word
//   valid_op          option is valid this cycle
//   started           high from first index word until done
//   done              high once finished, cleared only by rst
//   timeout           sticky, issue budget exhausted
//   err               sticky, bad load index / option overflow / empty line
//   lines_issued      saturating count of index words emitted
module line_option_feeder #(
  parameter int unsigned SIZE       = 3,
  parameter int unsigned MAX_OPTS   = 8,
  parameter int unsigned MAX_ISSUES = 1023,
  localparam int unsigned LW        = $clog2(2 * SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [LW-1:0]   load_line,
  input  logic [SIZE-1:0] load_opt,
  input  logic            start,
  input  logic            put_back_to_FIFO,
  input  logic            solved,
  output logic [SIZE-1:0] option,
  output logic            valid_op,
  output logic            started,
  output logic            done,
  output logic            timeout,
  output logic            err,
  output logic [15:0]     lines_issued
);

  localparam int unsigned NL = 2 * SIZE;
  localparam int unsigned CW = $clog2(MAX_OPTS + 1);
  localparam int unsigned OW = (MAX_OPTS > 1) ? $clog2(MAX_OPTS) : 1;
  localparam int unsigned QW = $clog2(NL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_INDEX,
    S_OPTS,
    S_RESULT,
    S_DONE
  } state_e;

  // Storage
  logic [SIZE-1:0] mem_q  [NL][MAX_OPTS];
  logic [CW-1:0]   cnt_q  [NL];
  logic [LW-1:0]   fifo_q [NL];

  // Control and output registers
  state_e          state_q,   state_d;
  logic [LW-1:0]   line_q,    line_d;
  logic [CW-1:0]   k_q,       k_d;
  logic [LW-1:0]   head_q,    head_d;
  logic [LW-1:0]   tail_q,    tail_d;
  logic [QW-1:0]   occ_q,     occ_d;
  logic [SIZE-1:0] option_q,  option_d;
  logic            valid_q,   valid_d;
  logic            started_q, started_d;
  logic            done_q,    done_d;
  logic            timeout_q, timeout_d;
  logic            err_q,     err_d;
  logic [15:0]     issued_q,  issued_d;

  // Storage write strobes from the control logic
  logic            mem_we;
  logic            q_fill;
  logic            q_push;

  // Shared lookups
  logic            load_ok;
  logic [CW-1:0]   load_cnt;
  logic [LW-1:0]   head_line;
  logic [CW-1:0]   head_cnt;
  logic [CW-1:0]   cur_cnt;
  logic [CW-1:0]   k_nxt;

  // Queue pointers wrap modulo the number of lines
  function automatic logic [LW-1:0] ptr_inc(input logic [LW-1:0] p);
    return (p == LW'(NL - 1)) ? '0 : p + LW'(1);
  endfunction

  assign load_ok   = (32'(load_line) < NL);
  assign load_cnt  = load_ok ? cnt_q[load_line] : '0;
  assign head_line = fifo_q[head_q];
  assign head_cnt  = cnt_q[head_line];
  assign cur_cnt   = cnt_q[line_q];
  assign k_nxt     = k_q + CW'(1);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      k_q       <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      option_q  <= '0;
      valid_q   <= 1'b0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      k_q       <= k_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      option_q  <= option_d;
      valid_q   <= valid_d;
      started_q <= started_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      issued_q  <= issued_d;
    end
  end

  // Option memory, per-line counts and line queue; reset clears loaded options
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        cnt_q[i]  <= '0;
        fifo_q[i] <= '0;
        for (int j = 0; j < MAX_OPTS; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      if (mem_we) begin
        mem_q[load_line][OW'(load_cnt)] <= load_opt;
        cnt_q[load_line]                <= load_cnt + CW'(1);
      end
      if (q_fill) begin
        for (int i = 0; i < NL; i++) begin
          fifo_q[i] <= LW'(i);
        end
      end else if (q_push) begin
        fifo_q[tail_q] <= line_q;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    k_d       = k_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    option_d  = '0;
    valid_d   = 1'b0;
    started_d = started_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    issued_d  = issued_q;
    mem_we    = 1'b0;
    q_fill    = 1'b0;
    q_push    = 1'b0;

    if (solved && (state_q != S_IDLE)) begin
      // Solver completion overrides everything, including a pending put-back
      state_d   = S_DONE;
      started_d = 1'b0;
      done_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A load coincident with start lands first; POP reads the new counts
          if (load_valid) begin
            if (load_ok && (load_cnt < CW'(MAX_OPTS))) begin
              mem_we = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (start) begin
            q_fill  = 1'b1;
            head_d  = '0;
            tail_d  = '0;
            occ_d   = QW'(NL);
            state_d = S_POP;
          end
        end

        S_POP: begin
          if (occ_q == '0) begin
            state_d   = S_DONE;
            started_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            head_d = ptr_inc(head_q);
            occ_d  = occ_q - QW'(1);
            if (head_cnt == '0) begin
              // Line without options: flag it and drop it
              err_d = 1'b1;
            end else begin
              line_d    = head_line;
              state_d   = S_INDEX;
              valid_d   = 1'b1;
              option_d  = SIZE'(head_line);
              started_d = 1'b1;
              if (issued_q != 16'hFFFF) begin
                issued_d = issued_q + 16'd1;
              end
            end
          end
        end

        S_INDEX: begin
          k_d      = '0;
          state_d  = S_OPTS;
          valid_d  = 1'b1;
          option_d = mem_q[line_q][0];
        end

        S_OPTS: begin
          if (k_nxt < cur_cnt) begin
            k_d      = k_nxt;
            valid_d  = 1'b1;
            option_d = mem_q[line_q][OW'(k_nxt)];
          end else begin
            state_d = S_RESULT;
          end
        end

        S_RESULT: begin
          if (put_back_to_FIFO) begin
            q_push = 1'b1;
            tail_d = ptr_inc(tail_q);
            occ_d  = occ_q + QW'(1);
          end
          if (32'(issued_q) >= MAX_ISSUES) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
            started_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = S_POP;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign option       = option_q;
  assign valid_op     = valid_q;
  assign started      = started_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign err          = err_q;
  assign lines_issued = issued_q;

endmodule

// File: tb/tb_line_option_feeder.sv
// Bench for line_option_feeder: two instances (default budget and a budget of 3)
// share stimulus; a queue-based model predicts every output on every cycle.
module tb_line_option_feeder;

  localparam int SZ  = 3;
  localparam int MO  = 8;
  localparam int NL  = 2 * SZ;
  localparam int NC  = 1024;
  localparam int BIG = 1 << 20;

  logic        clk = 1'b0;
  logic        rst, load_valid, start, put_back, solved;
  logic [2:0]  load_line, load_opt;
  logic [2:0]  opt0, opt1;
  logic        v0, v1, st0, st1, dn0, dn1, to0, to1, er0, er1;
  logic [15:0] li0, li1;

  always #5 clk = ~clk;

  line_option_feeder #(.SIZE(SZ), .MAX_OPTS(MO), .MAX_ISSUES(1023)) dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_line(load_line),
    .load_opt(load_opt), .start(start), .put_back_to_FIFO(put_back), .solved(solved),
    .option(opt0), .valid_op(v0), .started(st0), .done(dn0), .timeout(to0),
    .err(er0), .lines_issued(li0));

  line_option_feeder #(.SIZE(SZ), .MAX_OPTS(MO), .MAX_ISSUES(3)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_line(load_line),
    .load_opt(load_opt), .start(start), .put_back_to_FIFO(put_back), .solved(solved),
    .option(opt1), .valid_op(v1), .started(st1), .done(dn1), .timeout(to1),
    .err(er1), .lines_issued(li1));

  int n_checks = 0;
  int n_errors = 0;

  // Model state: loaded board, stimulus tables, expected per-cycle outputs
  int         mem_m [NL][MO];
  int         cnt_m [NL];
  bit         load_err;
  int         ld_line [$];
  int         ld_opt [$];
  bit         pbi [64];
  bit         pb_cyc [NC];
  int         noise_mode;
  int         s_cyc;
  bit         e_valid [2][NC];
  logic [2:0] e_opt [2][NC];
  int         e_iss [2][NC];
  int         done_at [2];
  int         to_at [2];
  int         err_at [2];
  int         cap_q [$];
  int         lit1 [18] = '{0, 6, 3, 1, 4, 2, 1, 2, 5, 3, 5, 4, 6, 3, 5, 4, 2, 1};

  task automatic chk(input string name, input int c, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
    end
  endtask

  task automatic begin_scn();
    for (int i = 0; i < NL; i++) cnt_m[i] = 0;
    load_err = 1'b0;
    ld_line.delete();
    ld_opt.delete();
    for (int i = 0; i < 64; i++) pbi[i] = 1'b0;
    noise_mode = 0;
    s_cyc = -1;
  endtask

  task automatic add_load(input int line, input int opt);
    ld_line.push_back(line);
    ld_opt.push_back(opt);
    if (line >= NL) load_err = 1'b1;
    else if (cnt_m[line] == MO) load_err = 1'b1;
    else begin
      mem_m[line][cnt_m[line]] = opt;
      cnt_m[line]++;
    end
  endtask

  task automatic load_board();
    add_load(0, 6); add_load(0, 3);
    add_load(1, 4); add_load(1, 2); add_load(1, 1);
    add_load(2, 5);
    add_load(3, 5);
    add_load(4, 6); add_load(4, 3);
    add_load(5, 4); add_load(5, 2); add_load(5, 1);
  endtask

  // Queue-level model: cycle 0 is the first POP cycle after start is sampled.
  // A line with n options: POP, index, n options, RESULT. gen=1 writes the
  // per-issue put-back decisions into the RESULT cycles of the stimulus table.
  task automatic run_model(input int inst, input int max_iss, input bit gen);
    int q[$];
    int c, r, issued, L, n;
    for (int i = 0; i < NC; i++) begin
      e_valid[inst][i] = 1'b0;
      e_opt[inst][i]   = 3'd0;
      e_iss[inst][i]   = 0;
    end
    for (int i = 0; i < NL; i++) q.push_back(i);
    c = 0;
    issued = 0;
    done_at[inst] = BIG;
    to_at[inst]   = BIG;
    err_at[inst]  = load_err ? 0 : BIG;
    while (done_at[inst] == BIG) begin
      if (q.size() == 0) begin
        done_at[inst] = c + 1;
      end else begin
        L = q.pop_front();
        n = cnt_m[L];
        if (n == 0) begin
          if (err_at[inst] == BIG) err_at[inst] = c + 1;
          c++;
        end else begin
          e_valid[inst][c + 1] = 1'b1;
          e_opt[inst][c + 1]   = 3'(L);
          e_iss[inst][c + 1]   = 1;
          for (int k = 0; k < n; k++) begin
            e_valid[inst][c + 2 + k] = 1'b1;
            e_opt[inst][c + 2 + k]   = 3'(mem_m[L][k]);
          end
          issued++;
          r = c + n + 2;
          if (gen) pb_cyc[r] = (issued <= 64) ? pbi[issued - 1] : 1'b0;
          if (pb_cyc[r]) q.push_back(L);
          if (issued >= max_iss) begin
            to_at[inst]   = r + 1;
            done_at[inst] = r + 1;
          end else begin
            c = r + 1;
          end
        end
      end
    end
    // Solver completion ends everything the edge after it is seen
    if (s_cyc >= 0 && s_cyc < done_at[inst]) begin
      done_at[inst] = s_cyc + 1;
      if (to_at[inst] > s_cyc) to_at[inst] = BIG;
      if (err_at[inst] > s_cyc) err_at[inst] = BIG;
      for (int i = s_cyc + 1; i < NC; i++) begin
        e_valid[inst][i] = 1'b0;
        e_iss[inst][i]   = 0;
      end
    end
    for (int i = 1; i < NC; i++) e_iss[inst][i] += e_iss[inst][i - 1];
  endtask

  task automatic chk_inst(input int i, input int c, input logic [2:0] o, input logic v,
                          input logic st, input logic dn, input logic to, input logic er,
                          input logic [15:0] li);
    bit dexp;
    dexp = (c >= done_at[i]);
    chk($sformatf("valid_op[%0d]", i), c, int'(v), int'(e_valid[i][c]));
    if (e_valid[i][c]) chk($sformatf("option[%0d]", i), c, int'(o), int'(e_opt[i][c]));
    chk($sformatf("done[%0d]", i), c, int'(dn), int'(dexp));
    chk($sformatf("started[%0d]", i), c, int'(st), int'(e_iss[i][c] > 0 && !dexp));
    chk($sformatf("timeout[%0d]", i), c, int'(to), int'(c >= to_at[i]));
    chk($sformatf("err[%0d]", i), c, int'(er), int'(c >= err_at[i]));
    chk($sformatf("lines_issued[%0d]", i), c, int'(li), e_iss[i][c]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_option0"}, 0, int'(opt0), 0);
    chk({tag, "_valid0"}, 0, int'(v0), 0);
    chk({tag, "_started0"}, 0, int'(st0), 0);
    chk({tag, "_done0"}, 0, int'(dn0), 0);
    chk({tag, "_timeout0"}, 0, int'(to0), 0);
    chk({tag, "_err0"}, 0, int'(er0), 0);
    chk({tag, "_issued0"}, 0, int'(li0), 0);
    chk({tag, "_valid1"}, 0, int'(v1), 0);
    chk({tag, "_done1"}, 0, int'(dn1), 0);
    chk({tag, "_issued1"}, 0, int'(li1), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; put_back = 1'b0; solved = 1'b0;
    load_line = 3'd0; load_opt = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("reset");
  endtask

  // Reset, load, start, then compare every cycle until both instances are done
  task automatic run_scn(input bit co_start, input int abort_c);
    int end_c;
    for (int i = 0; i < NC; i++) begin
      case (noise_mode)
        0:       pb_cyc[i] = 1'b0;
        1:       pb_cyc[i] = 1'b1;
        default: pb_cyc[i] = 1'($urandom_range(0, 1));
      endcase
    end
    run_model(0, 1023, 1'b1);
    run_model(1, 3, 1'b0);
    end_c = ((done_at[0] > done_at[1]) ? done_at[0] : done_at[1]) + 3;
    if (end_c > NC - 1) end_c = NC - 1;
    do_reset();
    cap_q.delete();
    for (int i = 0; i < ld_line.size(); i++) begin
      load_valid = 1'b1;
      load_line  = 3'(ld_line[i]);
      load_opt   = 3'(ld_opt[i]);
      if (co_start && i == ld_line.size() - 1) start = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
    end
    if (!(co_start && ld_line.size() > 0)) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int c = 0; c <= end_c; c++) begin
      put_back = pb_cyc[c];
      solved   = (c == s_cyc);
      if (c == abort_c) begin
        solved = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        break;
      end
      @(negedge clk);
      chk_inst(0, c, opt0, v0, st0, dn0, to0, er0, li0);
      chk_inst(1, c, opt1, v1, st1, dn1, to1, er1, li1);
      if (v0) cap_q.push_back(int'(opt0));
      @(posedge clk); #1;
    end
    put_back = 1'b0;
    solved   = 1'b0;
  endtask

  task automatic chk_stream1(input string tag);
    chk({tag, "_len"}, 0, cap_q.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i < cap_q.size()) chk({tag, "_word"}, i, cap_q[i], lit1[i]);
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; put_back = 1'b0; solved = 1'b0;
    load_line = 3'd0; load_opt = 3'd0;

    // Board streamed once with no put-backs
    begin_scn(); load_board();
    run_scn(1'b0, -1);
    chk_stream1("s1_stream");
    chk("s1_issued", 0, int'(li0), 6);
    chk("s1_done", 0, int'(dn0), 1);

    // Lines 0 and 1 handed back on their first pass
    begin_scn(); load_board();
    pbi[0] = 1'b1; pbi[1] = 1'b1; noise_mode = 2;
    run_scn(1'b0, -1);
    chk("s2_issued", 0, int'(li0), 8);

    // Solved during row1's second option word
    begin_scn(); load_board();
    s_cyc = 8;
    run_scn(1'b1, -1);
    chk("s3_words", 0, cap_q.size(), 6);
    chk("s3_issued", 0, int'(li0), 2);
    chk("s3_valid", 0, int'(v0), 0);
    chk("s3_done", 0, int'(dn0), 1);

    // Option overflow on line 2, empty line 4
    begin_scn();
    add_load(0, 6); add_load(1, 4); add_load(3, 5); add_load(5, 2);
    for (int i = 0; i < 9; i++) add_load(2, i % 8);
    run_scn(1'b0, -1);
    chk("s4_issued", 0, int'(li0), 5);
    chk("s4_err", 0, int'(er0), 1);

    // Put-back held high: the budget-3 instance times out
    begin_scn(); load_board();
    for (int i = 0; i < 40; i++) pbi[i] = 1'b1;
    noise_mode = 1;
    run_scn(1'b0, -1);
    chk("s5_issued", 0, int'(li1), 3);
    chk("s5_timeout", 0, int'(to1), 1);
    chk("s5_done", 0, int'(dn1), 1);

    // Reset mid-OPTS, then replay the first scenario
    begin_scn(); load_board();
    run_scn(1'b0, 2);
    begin_scn(); load_board();
    run_scn(1'b0, -1);
    chk_stream1("s6_replay");

    // Randomized boards, put-back patterns and solver completion
    for (int it = 0; it < 20; it++) begin
      begin_scn();
      if ($urandom_range(0, 3) == 0) add_load(6 + $urandom_range(0, 1), $urandom_range(0, 7));
      for (int l = 0; l < NL; l++) begin
        int n;
        n = $urandom_range(1, 4);
        if ($urandom_range(0, 5) == 0) n = 0;
        if ($urandom_range(0, 7) == 0) n = MO + 1;
        for (int k = 0; k < n; k++) add_load(l, $urandom_range(0, 7));
      end
      for (int i = 0; i < 40; i++) pbi[i] = ($urandom_range(0, 2) == 0);
      noise_mode = 2;
      s_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 150) : -1;
      run_scn(1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
